// File: rtl/ysyx_22040088_ifu_fetch.sv
// Instruction fetch unit: owns the architectural PC, fetches one 32-bit
// instruction per transaction over a valid/ready request + valid response bus,
// hands {pc, inst, err} to the decoder and waits for the executed nextpc.
// Non-pipelined: exactly one instruction is in flight at any time.
// Every output comes straight from a register, so no input reaches an output
// through logic alone.
module ysyx_22040088_ifu_fetch #(
  parameter logic [63:0] RESET_PC = 64'h8000_0000,
  parameter int          DATA_W   = 64
) (
  input  logic              clk,
  input  logic              rst,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [63:0]       req_addr,
  input  logic              rsp_valid,
  input  logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_err,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [63:0]       out_pc,
  output logic [31:0]       out_inst,
  output logic              out_err,
  input  logic              nextpc_valid,
  input  logic [63:0]       nextpc
);

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ     = 3'd1,
    WAIT    = 3'd2,
    DELIVER = 3'd3,
    WAITPC  = 3'd4
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic        req_valid_q, req_valid_d;
  logic        out_valid_q, out_valid_d;
  logic [63:0] out_pc_q, out_pc_d;
  logic [31:0] out_inst_q, out_inst_d;
  logic        out_err_q, out_err_d;

  // The 32-bit word of the response that holds the instruction at pc.
  logic [31:0] rsp_word;

  generate
    if (DATA_W == 64) begin : g_rsp64
      // pc[2] picks the upper or lower half of the doubleword.
      assign rsp_word = pc_q[2] ? rsp_data[DATA_W-1:32] : rsp_data[31:0];
    end else begin : g_rsp32
      assign rsp_word = rsp_data[31:0];
    end
  endgenerate

  // Next-state and next-output logic for the fetch FSM.
  always_comb begin
    // NOTE: every target gets a hold value first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    out_err_d   = out_err_q;

    unique case (state_q)
      IDLE: begin
        state_d     = REQ;
        req_valid_d = (pc_q[1:0] == 2'b00);
      end

      REQ: begin
        if (pc_q[1:0] != 2'b00) begin
          // Misaligned PC: never touch the bus, report a fault with a nop.
          req_valid_d = 1'b0;
          out_valid_d = 1'b1;
          out_pc_d    = pc_q;
          out_inst_d  = NOP_INST;
          out_err_d   = 1'b1;
          state_d     = DELIVER;
        end else if (req_valid_q && req_ready) begin
          req_valid_d = 1'b0;
          state_d     = WAIT;
        end
      end

      WAIT: begin
        if (rsp_valid) begin
          out_valid_d = 1'b1;
          out_pc_d    = pc_q;
          out_inst_d  = rsp_err ? NOP_INST : rsp_word;
          out_err_d   = rsp_err;
          state_d     = DELIVER;
        end
      end

      DELIVER: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_err_d   = 1'b0;
          state_d     = WAITPC;
        end
      end

      WAITPC: begin
        if (nextpc_valid) begin
          pc_d        = nextpc;
          req_valid_d = (nextpc[1:0] == 2'b00);
          state_d     = REQ;
        end
      end

      default: begin
        state_d     = IDLE;
        req_valid_d = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_pc_q    <= RESET_PC;
      out_inst_q  <= 32'h0;
      out_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_err_q   <= out_err_d;
    end
  end

  assign req_valid = req_valid_q;
  assign req_addr  = {pc_q[63:2], 2'b00};
  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_ysyx_22040088_ifu_fetch.sv
// Self-checking bench for ysyx_22040088_ifu_fetch: expected deliveries are
// queued when the response (or nextpc) is driven, popped when out_valid shows.
module tb_ysyx_22040088_ifu_fetch;

  localparam logic [63:0] RESET_PC = 64'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [63:0] DATA_A   = 64'hAAAA_BBBB_0010_0093;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid;
  logic        req_ready = 1'b0;
  logic [63:0] req_addr;
  logic        rsp_valid = 1'b0;
  logic [63:0] rsp_data = '0;
  logic        rsp_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_pc;
  logic [31:0] out_inst;
  logic        out_err;
  logic        nextpc_valid = 1'b0;
  logic [63:0] nextpc = '0;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;
  int   cyc    = 0;
  int   n_req  = 0;
  int   n_del  = 0;
  int   out_cyc = 0;

  ysyx_22040088_ifu_fetch #(.RESET_PC(RESET_PC), .DATA_W(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pc       (out_pc),
    .out_inst     (out_inst),
    .out_err      (out_err),
    .nextpc_valid (nextpc_valid),
    .nextpc       (nextpc)
  );

  always #5 clk = ~clk;

  // Cycle counter and handshake counters, sampled at the active edge.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && req_valid && req_ready) n_req <= n_req + 1;
    if (!rst && out_valid && out_ready) n_del <= n_del + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_req_valid"}, req_valid, 0);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_pc"},    out_pc,    RESET_PC);
    check({tag, "_out_inst"},  out_inst,  0);
    check({tag, "_out_err"},   out_err,   0);
  endtask

  // Wait (bounded) for out_valid, compare against the scoreboard head,
  // optionally stall the decoder, then accept.
  task automatic deliver(input int out_stall);
    exp_t e;
    bit   seen = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    check("out_seen", seen, 1);
    out_cyc = cyc;
    if (sb.size() == 0) begin
      check("sb_nonempty", 0, 1);
      return;
    end
    e = sb.pop_front();
    check("out_pc",   out_pc,   e.pc);
    check("out_inst", out_inst, e.inst);
    check("out_err",  out_err,  e.err);
    for (int k = 0; k < out_stall; k++) begin
      out_ready = 1'b0;
      @(negedge clk);
      check("out_hold_valid", out_valid, 1);
      check("out_hold_inst",  out_inst,  e.inst);
      check("out_hold_pc",    out_pc,    e.pc);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("out_drop_valid", out_valid, 0);
    check("out_drop_err",   out_err,   0);
  endtask

  // Complete one aligned fetch at pc: request, response, delivery.
  task automatic fetch(input logic [63:0] pc, input logic [63:0] data, input logic err,
                       input int req_stall, input int out_stall);
    exp_t        e;
    bit          seen = 0;
    logic [63:0] addr_exp;
    addr_exp = {pc[63:2], 2'b00};
    for (int k = 0; k < 20; k++) begin
      if (req_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    check("req_seen", seen, 1);
    check("req_addr", req_addr, addr_exp);
    for (int k = 0; k < req_stall; k++) begin
      req_ready = 1'b0;
      @(negedge clk);
      check("req_hold_valid", req_valid, 1);
      check("req_hold_addr",  req_addr,  addr_exp);
      check("req_hold_noout", out_valid, 0);
    end
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    check("req_drop", req_valid, 0);
    e.pc   = pc;
    e.err  = err;
    e.inst = err ? NOP : (pc[2] ? data[63:32] : data[31:0]);
    sb.push_back(e);
    rsp_valid = 1'b1;
    rsp_data  = data;
    rsp_err   = err;
    @(negedge clk);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    deliver(out_stall);
  endtask

  task automatic send_nextpc(input logic [63:0] pc);
    nextpc_valid = 1'b1;
    nextpc       = pc;
    @(negedge clk);
    nextpc_valid = 1'b0;
  endtask

  initial begin
    int   rel_cyc;
    int   req0;
    int   del0;
    bit   saw_req;
    bit   seen;
    exp_t e;

    // Reset and initial state.
    repeat (3) @(negedge clk);
    check_reset_state("rst");
    rst = 1'b0;
    rel_cyc = cyc;

    // 1: first fetch at RESET_PC, low half of the doubleword; delivery latency.
    fetch(RESET_PC, DATA_A, 1'b0, 0, 0);
    check("t1_latency", out_cyc - rel_cyc, 3);

    // 2: pc[2]=1 selects the upper half.
    send_nextpc(64'h8000_0004);
    fetch(64'h8000_0004, DATA_A, 1'b0, 0, 0);

    // 3: request and delivery back-pressure, one transfer each.
    send_nextpc(64'h8000_0008);
    req0 = n_req;
    del0 = n_del;
    fetch(64'h8000_0008, 64'h1234_5678_0000_0517, 1'b0, 5, 3);
    check("t3_req_count", n_req - req0, 1);
    check("t3_del_count", n_del - del0, 1);

    // 4: bus error delivers a faulting nop; the next fetch is clean.
    send_nextpc(64'h8000_000C);
    fetch(64'h8000_000C, 64'hDEAD_BEEF_CAFE_F00D, 1'b1, 0, 0);
    send_nextpc(64'h8000_0010);
    fetch(64'h8000_0010, 64'h0000_0000_0040_0113, 1'b0, 0, 1);

    // 5: misaligned nextpc faults without a bus request.
    e.pc   = 64'h8000_0006;
    e.inst = NOP;
    e.err  = 1'b1;
    sb.push_back(e);
    req0 = n_req;
    send_nextpc(64'h8000_0006);
    saw_req = 0;
    seen    = 0;
    for (int k = 0; k < 10; k++) begin
      if (req_valid) saw_req = 1;
      if (out_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    check("t5_out_seen", seen, 1);
    check("t5_no_req_valid", saw_req, 0);
    deliver(0);
    check("t5_req_count", n_req - req0, 0);

    // 6: reset while waiting for the response; a stray response is ignored.
    send_nextpc(64'h8000_0100);
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      if (req_valid) begin seen = 1; break; end
      @(negedge clk);
    end
    check("t6_req_seen", seen, 1);
    check("t6_req_addr", req_addr, 64'h8000_0100);
    req_ready = 1'b1;
    @(negedge clk);
    req_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("t6_rst");
    rst       = 1'b0;
    rsp_valid = 1'b1;
    rsp_data  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    rsp_valid = 1'b0;
    check("t6_stray_out_valid", out_valid, 0);
    check("t6_restart_addr", req_addr, RESET_PC);
    fetch(RESET_PC, DATA_A, 1'b0, 0, 0);

    check("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
